// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter of ALU/LSB result FIFOs onto the registered common data bus
module cdb_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ROB_ID_W = 4,
   parameter int DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rollback_signal,
   input  logic                alu_valid,
   input  logic [ROB_ID_W-1:0] alu_alias,
   input  logic [DATA_W-1:0]   alu_value,
   input  logic                alu_jump_res,
   input  logic [DATA_W-1:0]   alu_jump_pc,
   output logic                alu_stall,
   input  logic                lsb_valid,
   input  logic [ROB_ID_W-1:0] lsb_alias,
   input  logic [DATA_W-1:0]   lsb_value,
   output logic                lsb_stall,
   output logic                cdb_valid,
   output logic                cdb_src,
   output logic [ROB_ID_W-1:0] cdb_alias,
   output logic [DATA_W-1:0]   cdb_value,
   output logic                cdb_jump_res,
   output logic [DATA_W-1:0]   cdb_jump_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ROB_ID_W-1:0] alu_alias_m [DEPTH];
   logic [DATA_W-1:0]   alu_value_m [DEPTH];
   logic                alu_jr_m    [DEPTH];
   logic [DATA_W-1:0]   alu_pc_m    [DEPTH];
   logic [ROB_ID_W-1:0] lsb_alias_m [DEPTH];
   logic [DATA_W-1:0]   lsb_value_m [DEPTH];
   logic [AW-1:0]       alu_hd, alu_tl, lsb_hd, lsb_tl;
   logic [CW-1:0]       alu_cnt, lsb_cnt;
   logic                last_grant;
   logic                active, alu_ne, lsb_ne, alu_push, lsb_push, gnt_alu, gnt_lsb;

   // Enqueue qualification, stall flags and round-robin grant, all from registered state
   always_comb begin
      active    = rdy & ~rollback_signal;
      alu_stall = alu_cnt == FULL;
      lsb_stall = lsb_cnt == FULL;
      alu_ne    = alu_cnt != '0;
      lsb_ne    = lsb_cnt != '0;
      alu_push  = active & alu_valid & ~alu_stall;
      lsb_push  = active & lsb_valid & ~lsb_stall;
      gnt_alu   = active & alu_ne & (~lsb_ne | last_grant);
      gnt_lsb   = active & lsb_ne & (~alu_ne | ~last_grant);
   end

   // FIFO storage; contents are only meaningful below the count, so no reset is needed
   always_ff @(posedge clk) begin
      if (alu_push) begin
         alu_alias_m[alu_tl] <= alu_alias;
         alu_value_m[alu_tl] <= alu_value;
         alu_jr_m[alu_tl]    <= alu_jump_res;
         alu_pc_m[alu_tl]    <= alu_jump_pc;
      end
      if (lsb_push) begin
         lsb_alias_m[lsb_tl] <= lsb_alias;
         lsb_value_m[lsb_tl] <= lsb_value;
      end
   end

   // FIFO pointers and counts; a rollback empties both queues
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_hd  <= '0;
         alu_tl  <= '0;
         alu_cnt <= '0;
         lsb_hd  <= '0;
         lsb_tl  <= '0;
         lsb_cnt <= '0;
      end else if (rdy && rollback_signal) begin
         alu_hd  <= '0;
         alu_tl  <= '0;
         alu_cnt <= '0;
         lsb_hd  <= '0;
         lsb_tl  <= '0;
         lsb_cnt <= '0;
      end else if (rdy) begin
         alu_tl  <= alu_push ? alu_tl + AW'(1) : alu_tl;
         alu_hd  <= gnt_alu ? alu_hd + AW'(1) : alu_hd;
         alu_cnt <= alu_cnt + CW'(alu_push) - CW'(gnt_alu);
         lsb_tl  <= lsb_push ? lsb_tl + AW'(1) : lsb_tl;
         lsb_hd  <= gnt_lsb ? lsb_hd + AW'(1) : lsb_hd;
         lsb_cnt <= lsb_cnt + CW'(lsb_push) - CW'(gnt_lsb);
      end
   end

   // CDB beat register and last-grant tracking; data fields hold when nothing is granted
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid    <= 1'b0;
         cdb_src      <= 1'b0;
         cdb_alias    <= '0;
         cdb_value    <= '0;
         cdb_jump_res <= 1'b0;
         cdb_jump_pc  <= '0;
         last_grant   <= 1'b1;
      end else if (rdy) begin
         cdb_valid <= gnt_alu | gnt_lsb;
         if (rollback_signal) begin
            last_grant <= 1'b1;
         end else if (gnt_alu) begin
            cdb_src      <= 1'b0;
            cdb_alias    <= alu_alias_m[alu_hd];
            cdb_value    <= alu_value_m[alu_hd];
            cdb_jump_res <= alu_jr_m[alu_hd];
            cdb_jump_pc  <= alu_pc_m[alu_hd];
            last_grant   <= 1'b0;
         end else if (gnt_lsb) begin
            cdb_src      <= 1'b1;
            cdb_alias    <= lsb_alias_m[lsb_hd];
            cdb_value    <= lsb_value_m[lsb_hd];
            cdb_jump_res <= 1'b0;
            cdb_jump_pc  <= '0;
            last_grant   <= 1'b1;
         end
      end
   end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) between the ALU and the LSB result producers. Each producer writes into a small private result FIFO; the arbiter picks one FIFO head per cycle, round-robin, and drives a registered CDB beat that the ROB, RS and LSB snoop. Producers are backpressured through per-source stall flags. All buffered results are discarded on a ROB rollback.

## Interface
- DATA_W, 32: width of result value and jump target PC.
- ROB_ID_W, 4: width of ROB alias (ROB_SIZE 16; alias 0 is never valid).
- DEPTH, 2: entries per source FIFO; power of two, at least 2.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback_signal  in  1  flush from ROB.
- alu_valid  in  1  ALU result offered this cycle.
- alu_alias  in  ROB_ID_W  ALU result's ROB alias.
- alu_value  in  DATA_W  ALU result value.
- alu_jump_res  in  1  branch taken flag.
- alu_jump_pc  in  DATA_W  branch taken target.
- alu_stall  out  1  ALU FIFO full; ALU must not assert alu_valid.
- lsb_valid  in  1  LSB result offered.
- lsb_alias  in  ROB_ID_W  LSB result's ROB alias.
- lsb_value  in  DATA_W  LSB load result.
- lsb_stall  out  1  LSB FIFO full.
- cdb_valid  out  1  CDB beat valid.
- cdb_src  out  1  0 = ALU, 1 = LSB.
- cdb_alias  out  ROB_ID_W  alias of broadcast result.
- cdb_value  out  DATA_W  broadcast value.
- cdb_jump_res  out  1  jump flag; 0 for LSB beats.
- cdb_jump_pc  out  DATA_W  jump target; 0 for LSB beats.

## Operation
- Per-source FIFO: head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH. LSB entries store alias and value only.
- Enqueue: a source's valid is sampled when rdy=1, rollback_signal=0 and its count<DEPTH. A valid presented while the FIFO is full is dropped. Dropping is a producer protocol violation and is not recovered.
- stall = (count==DEPTH). It is derived from registered state only. A full FIFO that dequeues this cycle still reports stall; there is no pass-through.
- Arbitration works on FIFO heads and only when rdy=1 and there is no flush.
  - Exactly one head non-empty: grant it.
  - Both non-empty: grant the source that was not granted last. Register last_grant updates only on a grant.
  - Neither non-empty: no grant.
- On grant: pop the head and load the CDB output registers with the head entry. cdb_src equals the granted source.
- No grant: cdb_valid<=0. The data fields hold their last values.
- Simultaneous enqueue and dequeue on one FIFO: count is unchanged and both pointers advance. An empty FIFO never bypasses its input to the CDB in the same cycle.
- Flush (rollback_signal=1, rdy=1): both counts and pointers go to 0, cdb_valid<=0, last_grant<=LSB. Inputs in the flush cycle are dropped.
- rdy=0: pointers, counts, last_grant and CDB registers hold, inputs are ignored, stall outputs remain valid.
- Reset values: cdb_valid=0, cdb_src=0, cdb_alias=0, cdb_value=0, cdb_jump_res=0, cdb_jump_pc=0, both FIFOs empty, alu_stall=0, lsb_stall=0, last_grant=LSB (so the first tie goes to the ALU).
- rst takes priority over rollback_signal and rdy.

## Timing
- Latency: a result sampled at edge t is on the CDB during the cycle after edge t+1, provided it wins arbitration at t+1.
- Throughput: one CDB beat per cycle. Under continuous contention the sources alternate, giving each 1 beat per 2 cycles.
- cdb_valid is a one-cycle pulse per result. Consumers sample it and no acknowledge is returned.
- A stall that rises at edge t blocks the source's valid during the cycle after t.
- Reset or flush is seen at edge t. From the cycle after t, cdb_valid=0 and the stall flags are 0.

## Test plan
- Single ALU result: alias 3, value 0x11, jump_res 1, jump_pc 0x1000 at edge 1. Required: cdb_valid=1 with src 0, alias 3, value 0x11, jump 1/0x1000 only in the cycle after edge 2.
- Contention: ALU (alias 2) and LSB (alias 5) are valid on the same edge, starting from reset. Required: ALU on the CDB first, LSB the next cycle.
- Sustained contention: both sources stay valid whenever their stall is 0, for 10 edges. Required: cdb_src strictly alternates 0,1,0,1… and no alias is lost or duplicated.
- Full/backpressure (DEPTH=2):
  - Setup: a third ALU result arrives before any drain.
  - Required: alu_stall=1 after two enqueues with no grant.
  - Required: alu_stall clears the cycle after a pop.
  - Required: wrap-around preserves FIFO order over 6 results.
- Flush: rollback_signal while both FIFOs hold 2 entries and cdb_valid=1. Required: cdb_valid=0 next cycle, stalls 0, none of the flushed aliases ever appear on the CDB.
- rdy: rdy=0 for 3 cycles with pending entries. Required: CDB registers and counts frozen; resume exactly where stopped.
